cube_servo_top: RTL and testbench

- Top of the Rubik's-cube robot controller. Receives single-byte commands over a UART RX line, decodes them, and drives eight hobby-servo PWM outputs.
- The outputs are four directional (arm-rotation) servos and four gripping servos.
- Contains the UART receiver with its baud-tick generator, a command decoder/pose register file, and eight PWM channels.

---
 rtl/cube_pkg.sv | 46 ++++
 rtl/uart_rx.sv | 156 +++++++++++++++
 rtl/cube_servo_top.sv | 141 ++++++++++++++
 tb/tb_cube_servo_top.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cube_pkg
//  Description : Shared constants for the cube-robot servo controller:
//                command byte codes, default servo pulse widths, default
//                frame length, UART receiver state encoding and the baud
//                divisor helper.
//  Revision    : 1.0  initial release
// ============================================================================
package cube_pkg;

  // Default timing (100 MHz clock, 50 Hz servo frame).
  localparam int DEF_CLK_FREQ_HZ   = 100_000_000;
  localparam int FRAME_CLK_DEF     = 2_000_000;
  localparam int PULSE_MIN_CLK_DEF = 100_000;
  localparam int PULSE_MID_CLK_DEF = 150_000;
  localparam int PULSE_MAX_CLK_DEF = 200_000;

  // Channel layout: indices 0..3 directional, 4..7 grippers.
  localparam int NUM_DIR   = 4;
  localparam int NUM_SERVO = 8;

  // Command bytes.
  localparam logic [7:0] CMD_SCAN  = 8'h62;
  localparam logic [7:0] CMD_LEFT  = 8'h61;
  localparam logic [7:0] CMD_RIGHT = 8'h63;
  localparam logic [7:0] CMD_UP    = 8'h64;
  localparam logic [7:0] CMD_DOWN  = 8'h65;
  localparam logic [7:0] CMD_GRIP1 = 8'h66;
  localparam logic [7:0] CMD_GRIP2 = 8'h67;
  localparam logic [7:0] CMD_GRIP3 = 8'h68;
  localparam logic [7:0] CMD_GRIP4 = 8'h69;

  // UART receiver states.
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Clocks per oversampling tick, rounded to nearest.
  function automatic int baud_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with free-running oversampling tick,
//                two-flop input synchroniser and IDLE/START/DATA/STOP FSM.
//                A start bit is re-checked mid-bit so short glitches are
//                rejected; a low stop bit discards the byte and blocks the
//                next start until the line has returned high.
//  Ports       : clk_i      system clock
//                rst_ni     asynchronous active-low reset
//                rx_i       serial line, idle high
//                rx_data_o  received byte, valid while rx_done_o is high
//                rx_done_o  one-clock pulse per correctly framed byte
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx
  import cube_pkg::*;
#(
  parameter int CLKS_PER_TICK = 651,
  parameter int OVERSAMPLE    = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_done_o
);

  localparam int DIV_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int TCK_W = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_TICK - 1);
  localparam logic [TCK_W-1:0] TCK_HALF = TCK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCK_W-1:0] TCK_LAST = TCK_W'(OVERSAMPLE - 1);

  logic [DIV_W-1:0] div_q;
  logic             rx_I_baud_tick;
  logic             sync1_q, sync2_q;
  logic [1:0]       state_q, state_d;
  logic [TCK_W-1:0] tick_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             done_q;
  logic             wait_high_q;
  logic             tick_end;
  logic             sample_bit, byte_ok, frame_err;

  // Free-running tick generator.
  assign rx_I_baud_tick = (div_q == DIV_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
    end else if (rx_I_baud_tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Synchroniser resets to the idle level so reset release never looks
  // like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end

  // Mid-bit for the start bit, full bit period elsewhere.
  assign tick_end = rx_I_baud_tick &&
                    (tick_cnt_q == ((state_q == RX_START) ? TCK_HALF : TCK_LAST));

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (rx_I_baud_tick && !wait_high_q && !sync2_q) state_d = RX_START;
      RX_START: if (tick_end) state_d = sync2_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_end && (bit_cnt_q == 3'd7)) state_d = RX_STOP;
      RX_STOP:  if (tick_end) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  // Output / datapath control.
  always_comb begin
    sample_bit = 1'b0;
    byte_ok    = 1'b0;
    frame_err  = 1'b0;
    case (state_q)
      RX_DATA: sample_bit = tick_end;
      RX_STOP: begin
        byte_ok   = tick_end && sync2_q;
        frame_err = tick_end && !sync2_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      wait_high_q <= 1'b0;
    end else begin
      if ((state_q == RX_IDLE) || tick_end) begin
        tick_cnt_q <= '0;
      end else if (rx_I_baud_tick) begin
        tick_cnt_q <= tick_cnt_q + TCK_W'(1);
      end

      if (state_q != RX_DATA) begin
        bit_cnt_q <= '0;
      end else if (sample_bit) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end

      // LSB arrives first, so shift in from the top.
      if (sample_bit) begin
        shift_q <= {sync2_q, shift_q[7:1]};
      end

      done_q <= byte_ok;
      if (byte_ok) begin
        data_q <= shift_q;
      end

      if (frame_err) begin
        wait_high_q <= 1'b1;
      end else if (sync2_q) begin
        wait_high_q <= 1'b0;
      end
    end
  end

  assign rx_data_o = data_q;
  assign rx_done_o = done_q;

endmodule
`default_nettype wire

// File: rtl/cube_servo_top.sv
`default_nettype none
// ============================================================================
//  Module      : cube_servo_top
//  Description : Rubik's-cube robot servo controller. Single-byte UART
//                commands update a shadow pose (four arm-rotation servos,
//                four grippers); the pose is copied into the active pulse
//                registers only at the frame wrap, so every PWM pulse is
//                whole. Outputs are registered compare results.
//  Ports       : I_sys_clk_top                      system clock
//                I_on_board_reset_n                 async active-low reset
//                I_rx_serial_data                   UART RX, idle high
//                o_servo1..4_directional_output_top arm-rotation PWM
//                o_servo1..4_gripping_output_top    gripper PWM
//  Revision    : 1.0  initial release
// ============================================================================
module cube_servo_top
  import cube_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = DEF_CLK_FREQ_HZ,
  parameter int BAUD_RATE     = 9600,
  parameter int OVERSAMPLE    = 16,
  parameter int PWM_FREQ_HZ   = DEF_CLK_FREQ_HZ / FRAME_CLK_DEF,
  parameter int PULSE_MIN_CLK = PULSE_MIN_CLK_DEF,
  parameter int PULSE_MID_CLK = PULSE_MID_CLK_DEF,
  parameter int PULSE_MAX_CLK = PULSE_MAX_CLK_DEF
) (
  input  logic I_sys_clk_top,
  input  logic I_on_board_reset_n,
  input  logic I_rx_serial_data,
  output logic o_servo1_directional_output_top,
  output logic o_servo2_directional_output_top,
  output logic o_servo3_directional_output_top,
  output logic o_servo4_directional_output_top,
  output logic o_servo1_gripping_output_top,
  output logic o_servo2_gripping_output_top,
  output logic o_servo3_gripping_output_top,
  output logic o_servo4_gripping_output_top
);

  localparam int FRAME_CLK = CLK_FREQ_HZ / PWM_FREQ_HZ;
  localparam int CNT_W     = $clog2(FRAME_CLK);
  localparam int TICK_DIV  = baud_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);

  typedef logic [CNT_W-1:0] pw_t;

  localparam pw_t P_MIN      = pw_t'(PULSE_MIN_CLK);
  localparam pw_t P_MID      = pw_t'(PULSE_MID_CLK);
  localparam pw_t P_MAX      = pw_t'(PULSE_MAX_CLK);
  localparam pw_t FRAME_LAST = pw_t'(FRAME_CLK - 1);

  logic [7:0] rx_data;
  logic       rx_done;

  uart_rx #(
    .CLKS_PER_TICK (TICK_DIV),
    .OVERSAMPLE    (OVERSAMPLE)
  ) uart (
    .clk_i     (I_sys_clk_top),
    .rst_ni    (I_on_board_reset_n),
    .rx_i      (I_rx_serial_data),
    .rx_data_o (rx_data),
    .rx_done_o (rx_done)
  );

  logic [NUM_SERVO-1:0][CNT_W-1:0] shadow_q, shadow_d;
  logic [NUM_SERVO-1:0][CNT_W-1:0] active_q;
  logic [NUM_SERVO-1:0]            pwm_q;
  pw_t                             cnt_q;
  logic                            frame_wrap;

  function automatic pw_t rst_pw(input int idx);
    return (idx < NUM_DIR) ? P_MID : P_MIN;
  endfunction

  // Anything not already at MAX goes to MAX.
  function automatic pw_t dir_toggle(input pw_t v);
    return (v == P_MAX) ? P_MID : P_MAX;
  endfunction

  function automatic pw_t grip_toggle(input pw_t v);
    return (v == P_MAX) ? P_MIN : P_MAX;
  endfunction

  // Command decoder: one byte per rx_done, unknown bytes leave the pose.
  always_comb begin
    shadow_d = shadow_q;
    if (rx_done) begin
      case (rx_data)
        CMD_SCAN: begin
          for (int i = 0; i < NUM_SERVO; i++) begin
            shadow_d[i] = (i < NUM_DIR) ? P_MID : P_MAX;
          end
        end
        CMD_LEFT:  shadow_d[0] = dir_toggle(shadow_q[0]);
        CMD_RIGHT: shadow_d[1] = dir_toggle(shadow_q[1]);
        CMD_UP:    shadow_d[2] = dir_toggle(shadow_q[2]);
        CMD_DOWN:  shadow_d[3] = dir_toggle(shadow_q[3]);
        CMD_GRIP1: shadow_d[4] = grip_toggle(shadow_q[4]);
        CMD_GRIP2: shadow_d[5] = grip_toggle(shadow_q[5]);
        CMD_GRIP3: shadow_d[6] = grip_toggle(shadow_q[6]);
        CMD_GRIP4: shadow_d[7] = grip_toggle(shadow_q[7]);
        default: ;
      endcase
    end
  end

  assign frame_wrap = (cnt_q == FRAME_LAST);

  // Active widths change only as the counter wraps to 0, so the compare
  // for the new frame already sees the new width.
  always_ff @(posedge I_sys_clk_top or negedge I_on_board_reset_n) begin
    if (!I_on_board_reset_n) begin
      for (int i = 0; i < NUM_SERVO; i++) begin
        shadow_q[i] <= rst_pw(i);
        active_q[i] <= rst_pw(i);
      end
      pwm_q <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q    <= frame_wrap ? '0 : (cnt_q + pw_t'(1));
      shadow_q <= shadow_d;
      if (frame_wrap) begin
        active_q <= shadow_q;
      end
      for (int i = 0; i < NUM_SERVO; i++) begin
        pwm_q[i] <= (cnt_q < active_q[i]);
      end
    end
  end

  assign o_servo1_directional_output_top = pwm_q[0];
  assign o_servo2_directional_output_top = pwm_q[1];
  assign o_servo3_directional_output_top = pwm_q[2];
  assign o_servo4_directional_output_top = pwm_q[3];
  assign o_servo1_gripping_output_top    = pwm_q[4];
  assign o_servo2_gripping_output_top    = pwm_q[5];
  assign o_servo3_gripping_output_top    = pwm_q[6];
  assign o_servo4_gripping_output_top    = pwm_q[7];

endmodule
`default_nettype wire

// File: tb/tb_cube_servo_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cube_servo_top
//  Description : Scoreboard bench for cube_servo_top using scaled timing
//                (1.6 MHz clock, 10 clocks per tick, 1000-clock frame,
//                pulses 50/75/100) so whole frames stay short.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cube_servo_top;

  localparam int CLK_HZ   = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int OS       = 16;
  localparam int PWM_HZ   = 1600;
  localparam int FRAME    = 1000;
  localparam int BIT_CLKS = 160;
  localparam int TICK_DIV = 10;

  typedef logic [7:0][15:0] pw_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic d1, d2, d3, d4, g1, g2, g3, g4;
  logic [7:0] outs;

  assign outs = {g4, g3, g2, g1, d4, d3, d2, d1};

  always #5 clk = ~clk;

  cube_servo_top #(
    .CLK_FREQ_HZ   (CLK_HZ),
    .BAUD_RATE     (BAUD),
    .OVERSAMPLE    (OS),
    .PWM_FREQ_HZ   (PWM_HZ),
    .PULSE_MIN_CLK (50),
    .PULSE_MID_CLK (75),
    .PULSE_MAX_CLK (100)
  ) uut (
    .I_sys_clk_top                   (clk),
    .I_on_board_reset_n              (rst_n),
    .I_rx_serial_data                (rx),
    .o_servo1_directional_output_top (d1),
    .o_servo2_directional_output_top (d2),
    .o_servo3_directional_output_top (d3),
    .o_servo4_directional_output_top (d4),
    .o_servo1_gripping_output_top    (g1),
    .o_servo2_gripping_output_top    (g2),
    .o_servo3_gripping_output_top    (g3),
    .o_servo4_gripping_output_top    (g4)
  );

  int checks = 0;
  int errors = 0;
  int rx_seen = 0;
  int rx_expected = 0;
  logic [7:0] exp_rx_q [$];
  pw_vec_t    exp_pw_q [$];
  string ch_name [8] = '{"dir1", "dir2", "dir3", "dir4", "grip1", "grip2", "grip3", "grip4"};

  function automatic pw_vec_t mk(input int a1, input int a2, input int a3, input int a4,
                                 input int b1, input int b2, input int b3, input int b4);
    pw_vec_t v;
    v[0] = 16'(a1); v[1] = 16'(a2); v[2] = 16'(a3); v[3] = 16'(a4);
    v[4] = 16'(b1); v[5] = 16'(b2); v[6] = 16'(b3); v[7] = 16'(b4);
    return v;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %02h required %02h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, exp);
    end
  endtask

  // Full 8N1 frame; a good stop bit registers the byte with the scoreboard.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) begin
      exp_rx_q.push_back(b);
      rx_expected++;
    end
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(BIT_CLKS);
    end
    rx = stop_bit;
    wait_clks(BIT_CLKS);
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
  endtask

  task automatic expect_pose(input pw_vec_t v);
    int n;
    exp_pw_q.push_back(v);
    n = 0;
    while (exp_pw_q.size() != 0 && n < 5 * FRAME) begin
      wait_clks(1);
      n++;
    end
  endtask

  // Receive monitor.
  initial begin : rx_monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && uut.rx_done) begin
        rx_seen++;
        checks++;
        if (exp_rx_q.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected got %02h required no byte", uut.rx_data);
        end else begin
          e = exp_rx_q.pop_front();
          if (uut.rx_data !== e) begin
            errors++;
            $display("FAIL rx_data got %02h required %02h", uut.rx_data, e);
          end
        end
      end
    end
  end

  // PWM monitor: measures one whole frame (all outputs rise together at
  // the frame start) per queued expectation.
  initial begin : pwm_monitor
    logic [7:0] prev;
    logic [7:0] fin;
    logic       measuring;
    int         waited;
    int         cnt [8];
    pw_vec_t    e;
    prev = 8'h00;
    fin = 8'h00;
    measuring = 1'b0;
    waited = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        measuring = 1'b0;
        waited = 0;
      end else if (exp_pw_q.size() != 0) begin
        waited++;
        if (!measuring) begin
          if (prev == 8'h00 && outs == 8'hFF) begin
            measuring = 1'b1;
            fin = 8'h00;
            for (int c = 0; c < 8; c++) cnt[c] = 1;
          end
        end else begin
          for (int c = 0; c < 8; c++) begin
            if (!fin[c]) begin
              if (outs[c]) cnt[c]++;
              else fin[c] = 1'b1;
            end
          end
          if (fin == 8'hFF) begin
            e = exp_pw_q.pop_front();
            for (int c = 0; c < 8; c++) begin
              checks++;
              if (cnt[c] != int'(e[c])) begin
                errors++;
                $display("FAIL pwm_%s got %0d clocks required %0d", ch_name[c], cnt[c], e[c]);
              end
            end
            measuring = 1'b0;
            waited = 0;
          end
        end
        if (waited > 3 * FRAME) begin
          checks++;
          errors++;
          $display("FAIL pwm_timeout got no complete frame required one within %0d clocks", 3 * FRAME);
          void'(exp_pw_q.pop_front());
          measuring = 1'b0;
          waited = 0;
        end
      end
      prev = outs;
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog got timeout required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int period;

    // Reset state.
    wait_clks(20);
    check8("reset_outputs", outs, 8'h00);
    rst_n = 1'b1;

    // Tick spacing and width.
    n = 0;
    while (!uut.uart.rx_I_baud_tick && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    check_int("tick_width", int'(uut.uart.rx_I_baud_tick), 0);
    period = 1;
    while (!uut.uart.rx_I_baud_tick && period < 100) begin @(negedge clk); period++; end
    check_int("tick_period", period, TICK_DIV);
    wait_clks(1);

    expect_pose(mk(75, 75, 75, 75, 50, 50, 50, 50));

    send_byte(8'h62, 1'b1);
    expect_pose(mk(75, 75, 75, 75, 100, 100, 100, 100));

    send_byte(8'h61, 1'b1);
    expect_pose(mk(100, 75, 75, 75, 100, 100, 100, 100));
    send_byte(8'h61, 1'b1);
    expect_pose(mk(75, 75, 75, 75, 100, 100, 100, 100));

    send_byte(8'h63, 1'b1);
    send_byte(8'h65, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'h68, 1'b1);
    expect_pose(mk(75, 100, 75, 100, 50, 100, 50, 100));
    send_byte(8'h64, 1'b1);
    send_byte(8'h69, 1'b1);
    expect_pose(mk(75, 100, 100, 100, 50, 100, 50, 50));

    // Unknown command.
    send_byte(8'h7A, 1'b1);
    expect_pose(mk(75, 100, 100, 100, 50, 100, 50, 50));

    // Framing error, then a good byte.
    send_byte(8'h61, 1'b0);
    expect_pose(mk(75, 100, 100, 100, 50, 100, 50, 50));
    send_byte(8'h61, 1'b1);
    expect_pose(mk(100, 100, 100, 100, 50, 100, 50, 50));

    // One-tick glitch on idle line.
    rx = 1'b0;
    wait_clks(TICK_DIV);
    rx = 1'b1;
    wait_clks(3 * BIT_CLKS);
    expect_pose(mk(100, 100, 100, 100, 50, 100, 50, 50));

    // Reset early in a frame while a byte is starting.
    n = 0;
    while (outs[0] && n < 2 * FRAME) begin wait_clks(1); n++; end
    while (!outs[0] && n < 4 * FRAME) begin wait_clks(1); n++; end
    wait_clks(20);
    rx = 1'b0;
    wait_clks(20);
    check8("pre_reset_high", outs, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check8("async_reset_outputs", outs, 8'h00);
    rx = 1'b1;
    wait_clks(5);
    check8("held_reset_outputs", outs, 8'h00);
    rst_n = 1'b1;
    expect_pose(mk(75, 75, 75, 75, 50, 50, 50, 50));

    wait_clks(2 * BIT_CLKS);
    check_int("rx_byte_count", rx_seen, rx_expected);
    check_int("rx_queue_left", exp_rx_q.size(), 0);
    check_int("pwm_queue_left", exp_pw_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
